// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with a runtime-loadable pattern,
// selectable overlap mode, a registered match flag and a saturating match counter.
module seq_detect_param #(
    parameter int unsigned    N       = 3,
    parameter logic [N-1:0]   DEF_PAT = 3'b101,
    parameter int unsigned    CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [N-1:0]     pattern_in,
    input  logic             overlap,
    input  logic             en,
    input  logic             x,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned FW = $clog2(N + 1);

    logic [N-1:0]     r_pat;
    logic [N-1:0]     r_hist;
    logic [FW-1:0]    r_fill;
    logic             r_match;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic [N-1:0]     w_shift;
    logic             w_hit;

    assign w_accept = en & ~load;
    assign w_shift  = {r_hist[N-2:0], x};
    // Only N-1 history bits plus the incoming bit are needed to complete a match.
    assign w_hit    = w_accept && (r_fill >= FW'(N - 1)) && (w_shift == r_pat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat   <= DEF_PAT;
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else if (load) begin
            r_pat   <= pattern_in;
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else if (en) begin
            r_hist  <= w_shift;
            r_match <= w_hit;
            // Zeroing fill keeps every bit of this match out of any later one.
            if (w_hit && !overlap) begin
                r_fill <= '0;
            end else if (r_fill != FW'(N)) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_hit && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign match     = r_match;
    assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default instance plus a 2-bit counter
// instance driven by the same stimulus.
module tb_seq_detect_param;

    logic       clk;
    logic       rst;
    logic       load;
    logic [2:0] pattern_in;
    logic       overlap;
    logic       en;
    logic       x;
    logic       cnt_clr;
    logic       match_a;
    logic [7:0] cnt_a;
    logic       match_b;
    logic [1:0] cnt_b;

    int unsigned checks = 0;
    int unsigned errors = 0;

    seq_detect_param #(.N(3), .DEF_PAT(3'b101), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .load(load), .pattern_in(pattern_in),
        .overlap(overlap), .en(en), .x(x), .cnt_clr(cnt_clr),
        .match(match_a), .match_cnt(cnt_a)
    );

    seq_detect_param #(.N(3), .DEF_PAT(3'b101), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .load(load), .pattern_in(pattern_in),
        .overlap(overlap), .en(en), .x(x), .cnt_clr(cnt_clr),
        .match(match_b), .match_cnt(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock with the given controls; inputs change 1 time unit after posedge.
    task automatic cyc(input logic e, input logic b, input logic clr);
        en = e; x = b; cnt_clr = clr;
        @(posedge clk);
        #1;
        en = 1'b0; x = 1'b0; cnt_clr = 1'b0;
    endtask

    // Load with en=1 and x=1 also present to exercise load priority.
    task automatic do_load(input logic [2:0] p);
        load = 1'b1; pattern_in = p; en = 1'b1; x = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0; en = 1'b0; x = 1'b0;
    endtask

    task automatic send_seq(input string tag, input logic [6:0] bits,
                            input logic [6:0] exp_m, input int unsigned len);
        for (int unsigned i = 0; i < len; i++) begin
            cyc(1'b1, bits[len-1-i], 1'b0);
            chk($sformatf("%s_bit%0d", tag, i + 1), 32'(match_a), 32'(exp_m[len-1-i]));
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; pattern_in = '0; overlap = 1'b1;
        en = 1'b0; x = 1'b0; cnt_clr = 1'b0;
        #2;
        chk("rst_match", 32'(match_a), 32'd0);
        chk("rst_cnt", 32'(cnt_a), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Overlapping 101 on 1010101
        overlap = 1'b1;
        send_seq("ovl", 7'b1010101, 7'b0010101, 7);
        chk("ovl_cnt", 32'(cnt_a), 32'd3);

        cyc(1'b0, 1'b0, 1'b1);
        chk("clr_cnt", 32'(cnt_a), 32'd0);
        chk("clr_hold_match", 32'(match_a), 32'd1);
        do_load(3'b101);
        chk("load_clears_match", 32'(match_a), 32'd0);

        // Non-overlapping 101 on 1010101
        overlap = 1'b0;
        send_seq("novl", 7'b1010101, 7'b0010001, 7);
        chk("novl_cnt", 32'(cnt_a), 32'd2);

        // Gap of en=0 inside a sequence
        overlap = 1'b1;
        do_load(3'b101);
        cyc(1'b0, 1'b0, 1'b1);
        send_seq("gap", 7'b0000010, 7'b0000000, 2);
        for (int unsigned i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0);
        chk("gap_idle", 32'(match_a), 32'd0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("gap_done", 32'(match_a), 32'd1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("gap_hold", 32'(match_a), 32'd1);
        chk("gap_cnt", 32'(cnt_a), 32'd1);

        // Pattern 110, then load mid-sequence
        do_load(3'b110);
        cyc(1'b0, 1'b0, 1'b1);
        send_seq("p110", 7'b0110110, 7'b0001001, 6);
        chk("p110_cnt", 32'(cnt_a), 32'd2);
        send_seq("p110_pre", 7'b0000011, 7'b0000000, 2);
        do_load(3'b110);
        chk("midload_match", 32'(match_a), 32'd0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("midload_nomatch", 32'(match_a), 32'd0);
        chk("midload_cnt", 32'(cnt_a), 32'd2);

        // All-ones with saturation on the 2-bit instance
        do_load(3'b111);
        cyc(1'b0, 1'b0, 1'b1);
        send_seq("ones", 7'b1111111, 7'b0011111, 7);
        chk("sat_cnt_a", 32'(cnt_a), 32'd5);
        chk("sat_cnt_b", 32'(cnt_b), 32'd3);
        cyc(1'b1, 1'b1, 1'b1);
        chk("clr_on_match_m", 32'(match_b), 32'd1);
        chk("clr_on_match_b", 32'(cnt_b), 32'd0);
        chk("clr_on_match_a", 32'(cnt_a), 32'd0);

        // Asynchronous reset between edges mid-stream; pattern returns to 101
        do_load(3'b101);
        send_seq("prerst", 7'b0000101, 7'b0000001, 3);
        chk("prerst_cnt", 32'(cnt_a), 32'd1);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_match", 32'(match_a), 32'd0);
        chk("async_cnt", 32'(cnt_a), 32'd0);
        rst = 1'b0;
        send_seq("postrst", 7'b0000101, 7'b0000001, 3);
        chk("postrst_cnt", 32'(cnt_a), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter N, default 3: pattern length in bits, legal range 2..16.
REQ-002 Parameter DEF_PAT, default 3'b101 (N bits): pattern value loaded at reset.
REQ-003 Parameter CNT_W, default 8: match counter width, legal range 1..32.
REQ-004 Port clk, input, 1: single clock; all state updates on posedge clk.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port load, input, 1: latches a new pattern from pattern_in on the current edge.
REQ-007 Port pattern_in, input, N: new pattern; bit N-1 = first serial bit expected.
REQ-008 Port overlap, input, 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-009 Port en, input, 1: serial bit valid; x is sampled only when en=1.
REQ-010 Port x, input, 1: serial data bit.
REQ-011 Port cnt_clr, input, 1: synchronous clear of match_cnt.
REQ-012 Port match, output, 1: registered Moore detect flag.
REQ-013 Port match_cnt, output, CNT_W: saturating count of detected matches.

Function
REQ-014 Internal state SHALL be: pattern register pat[N-1:0], history register hist[N-1:0], fill counter fill (0..N), match register, counter register.
REQ-015 On an edge with en=1 and load=0, hist SHALL become {hist[N-2:0], x}, and fill SHALL increment, saturating at N.
REQ-016 A match SHALL be declared on an accepted edge when fill before the edge >= N-1 and {hist[N-2:0], x} == pat.
REQ-017 match SHALL be 1 from the edge that accepts the completing bit until the next accepted edge or load; it is a Moore output with no combinational path from x, en or overlap.
REQ-018 On an edge with en=0 and load=0, hist, fill and match SHALL hold their values.
REQ-019 Overlap mode (overlap=1): after a match, hist and fill SHALL update normally, so suffix bits of one match may begin the next match.
REQ-020 Non-overlap mode (overlap=0): on a match edge, fill SHALL be set to 0, so no bit of a matched sequence contributes to a later match.
REQ-021 overlap SHALL be sampled on each accepted edge; a mode change affects only matches completed on or after that edge.
REQ-022 On a match edge, match_cnt SHALL increment by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-023 load=1 SHALL set pat to pattern_in, clear hist, fill and match to 0, and discard x on that edge; match_cnt is unaffected.
REQ-024 load SHALL take priority over en when both are 1.
REQ-025 cnt_clr=1 SHALL set match_cnt to 0 on that edge; if a match occurs on the same edge, the clear wins and the result is 0.
REQ-026 match SHALL still assert on a cnt_clr edge.
REQ-027 All-zero and all-one patterns SHALL be legal; an all-ones pattern with overlap=1 matches on every accepted 1 once fill = N.

Reset
REQ-028 Asserting rst SHALL immediately set pat = DEF_PAT, hist = 0, fill = 0, match = 0 and match_cnt = 0, independent of clk.
REQ-029 While rst=1, all inputs SHALL be ignored.
REQ-030 After rst deasserts, the first accepted bit SHALL be on the first posedge with en=1.
REQ-031 rst asserted mid-sequence SHALL discard partial history; no match may complete using bits accepted before reset.

Verification
REQ-032 Defaults (N=3, 101), overlap=1, en=1, x=1,0,1,0,1,0,1 -> match high after bits 3, 5 and 7; match_cnt=3.
REQ-033 Same stream with overlap=0 -> match high after bits 3 and 7 only; match_cnt=2.
REQ-034 Send x=1,0, then hold en=0 for 4 cycles, then send x=1 -> match asserts after the final 1; match stays high while en=0 follows.
REQ-035 Load pattern_in=3'b110, send x=1,1,0,1,1,0 with overlap=1 -> 2 matches; a load issued mid-sequence after 1,1 followed by 0 -> no match.
REQ-036 With CNT_W=2, 5 matches -> match_cnt saturates at 3; cnt_clr on a match edge -> match_cnt=0 and match=1.
REQ-037 rst pulse asserted between clock edges mid-stream -> match and match_cnt go to 0 before the next edge; the partial sequence is not completed.
